// File: rtl/gated_boxcar_if.sv
// gated_boxcar_if
// Sample-stream bundle for the gated boxcar filter.
//   gate        sample strobe, din accepted on every rising edge with gate=1
//   din         signed input sample, dw bits
//   dout        signed running sum of the last 2**lw accepted samples, dw+lw bits
//   avg         signed mean of the window (dout >>> lw), dw bits
//   dout_valid  one-cycle pulse marking an update of dout/avg
//   primed      high once a full window has been accepted since reset
// master drives samples in and reads results; slave is the filter itself.
interface gated_boxcar_if #(
  parameter int dw = 18,
  parameter int lw = 4
);
  logic                    gate;
  logic signed [dw-1:0]    din;
  logic signed [dw+lw-1:0] dout;
  logic signed [dw-1:0]    avg;
  logic                    dout_valid;
  logic                    primed;

  modport master (
    output gate,
    output din,
    input  dout,
    input  avg,
    input  dout_valid,
    input  primed
  );

  modport slave (
    input  gate,
    input  din,
    output dout,
    output avg,
    output dout_valid,
    output primed
  );
endinterface

// File: rtl/gated_boxcar.sv
// gated_boxcar
// Gated moving-sum filter: keeps the sum of the last N = 2**lw gated samples by
// adding each new sample and subtracting the one accepted N gates earlier,
// using an internal circular buffer.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; clears sum, outputs, pointer and fill
//   bus    gated_boxcar_if.slave (gate, din in; dout, avg, dout_valid, primed out)
// Parameters: dw sample width, lw log2 window length (1..6).
module gated_boxcar #(
  parameter int dw = 18,
  parameter int lw = 4
) (
  input  logic           clk,
  input  logic           reset,
  gated_boxcar_if.slave  bus
);

  localparam int n  = 1 << lw;
  localparam int ow = dw + lw;
  localparam logic [lw:0] fill_max = {1'b1, {lw{1'b0}}};

  logic signed [dw-1:0] buf_mem [n];
  logic [lw-1:0]        wptr;
  logic [lw:0]          fill;
  logic signed [ow-1:0] sum;
  logic signed [dw-1:0] avg_q;
  logic                 valid_q;
  logic                 primed_q;

  logic                 full;
  logic signed [dw-1:0] old;
  logic signed [ow-1:0] sum_next;
  logic [lw:0]          fill_next;

  // Until a full window has been written the buffer holds stale data from
  // before reset (or nothing at all), so the outgoing sample is forced to 0.
  // The read is combinational, so a read-modify-write of buf_mem[wptr] on the
  // same edge sees the pre-write value.
  always_comb begin
    full      = (fill == fill_max);
    old       = full ? buf_mem[wptr] : '0;
    sum_next  = sum + {{lw{bus.din[dw-1]}}, bus.din}
                    - {{lw{old[dw-1]}}, old};
    fill_next = full ? fill : fill + (lw+1)'(1);
  end

  // Buffer contents are deliberately not reset; the fill mask covers them.
  always_ff @(posedge clk) begin
    if (bus.gate) begin
      buf_mem[wptr] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      fill     <= '0;
      sum      <= '0;
      avg_q    <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      valid_q <= bus.gate;
      if (bus.gate) begin
        wptr     <= wptr + lw'(1);
        fill     <= fill_next;
        sum      <= sum_next;
        avg_q    <= sum_next[ow-1:lw];
        primed_q <= (fill_next == fill_max);
      end
    end
  end

  assign bus.dout       = sum;
  assign bus.avg        = avg_q;
  assign bus.dout_valid = valid_q;
  assign bus.primed     = primed_q;

endmodule

// File: tb/tb_gated_boxcar.sv
module tb_gated_boxcar;
  localparam int dw = 18;
  localparam int lw = 4;
  localparam int n  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gated_boxcar_if #(.dw(dw), .lw(lw)) bus ();

  gated_boxcar #(.dw(dw), .lw(lw)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: the accepted samples of the current window
  int q[$];
  int acc_cnt = 0;

  typedef struct {
    bit     gate;
    int     din;
    longint dout;
    longint avg;
    bit     valid;
    bit     primed;
  } vec_t;

  vec_t tbl[40];

  function automatic longint floor16(longint v);
    longint r;
    r = v % 16;
    if (r < 0) r += 16;
    return (v - r) / 16;
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(string tag, longint ed, longint ea, bit ev, bit ep);
    check({tag, " dout"},       longint'(bus.dout),       ed);
    check({tag, " avg"},        longint'(bus.avg),        ea);
    check({tag, " dout_valid"}, longint'(bus.dout_valid), longint'(ev));
    check({tag, " primed"},     longint'(bus.primed),     longint'(ep));
  endtask

  task automatic model_clear();
    q.delete();
    acc_cnt = 0;
  endtask

  // drive one cycle, update the window model, compare every output
  task automatic step(bit g, int d, string tag);
    longint s;
    bit acc;
    bus.gate = g;
    bus.din  = dw'(d);
    @(posedge clk);
    acc = g && !reset;
    if (acc) begin
      q.push_back(d);
      if (q.size() > n) q.delete(0);
      acc_cnt++;
    end
    #1;
    s = 0;
    foreach (q[i]) s += q[i];
    check_outputs(tag, s, floor16(s), acc, acc_cnt >= n);
  endtask

  task automatic do_reset(int cycles);
    reset    = 1'b1;
    bus.gate = 1'b1;
    bus.din  = dw'(1234);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check_outputs("reset", 0, 0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    bus.gate = 1'b0;
    bus.din  = '0;

    for (int i = 0; i < 40; i++) begin
      longint k;
      k = (i + 1 < n) ? longint'(i + 1) : longint'(n);
      tbl[i] = '{gate: 1'b1, din: 100, dout: k * 100, avg: (k * 100) / 16,
                 valid: 1'b1, primed: (i >= n - 1)};
    end

    do_reset(10);

    // constant input, table-driven
    for (int i = 0; i < 40; i++) begin
      bus.gate = tbl[i].gate;
      bus.din  = dw'(tbl[i].din);
      @(posedge clk);
      #1;
      check_outputs("const", tbl[i].dout, tbl[i].avg, tbl[i].valid, tbl[i].primed);
    end

    // ramp over several windows
    do_reset(2);
    for (int k = 0; k < 100; k++) begin
      step(1'b1, k, "ramp");
      if (k >= 15) check("ramp formula", longint'(bus.dout), 16 * longint'(k) - 120);
    end

    // extremes
    do_reset(2);
    for (int i = 0; i < 16; i++) step(1'b1, -131072, "ext_neg");
    check("ext_neg dout", longint'(bus.dout), -2097152);
    check("ext_neg avg",  longint'(bus.avg),  -131072);
    for (int i = 0; i < 16; i++) step(1'b1, 131071, "ext_pos");
    check("ext_pos dout", longint'(bus.dout), 2097136);
    check("ext_pos avg",  longint'(bus.avg),  131071);

    // sparse gate, 1 in 5
    do_reset(2);
    for (int i = 0; i < 80; i++) step((i % 5) == 0, 7, "sparse");
    check("sparse final dout", longint'(bus.dout), 112);

    // mid-operation asynchronous reset
    do_reset(2);
    for (int i = 0; i < 20; i++) step(1'b1, 50, "prime50");
    bus.din = dw'(3);
    #3 reset = 1'b1;
    #1;
    check_outputs("async_rst", 0, 0, 1'b0, 1'b0);
    model_clear();
    @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3, "after_rst");
      if (i == 15) begin
        check("after_rst dout16", longint'(bus.dout), 48);
        check("after_rst primed16", longint'(bus.primed), 1);
      end
    end

    // randomized bursts against the window model
    for (int b = 0; b < 3; b++) begin
      do_reset(2);
      for (int i = 0; i < 500; i++) begin
        bit g;
        int d;
        g = ($urandom_range(0, 3) != 0);
        d = int'($urandom_range(0, 262143)) - 131072;
        step(g, d, "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
